// File: rtl/eda_regional_max_pkg.sv
// ============================================================================
// Module : eda_regional_max_pkg
// Brief  : Shared defaults, FSM state encoding and {i,j} address type for the
//          regional-maximum detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package eda_regional_max_pkg;

  localparam int c_M_DEFAULT            = 4;
  localparam int c_N_DEFAULT            = 4;
  localparam int c_PIXEL_WIDTH_DEFAULT  = 8;
  localparam int c_WINDOW_WIDTH_DEFAULT = 3;
  localparam int c_I_WIDTH_DEFAULT      = 2;
  localparam int c_J_WIDTH_DEFAULT      = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SWEEP = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [c_I_WIDTH_DEFAULT-1:0] i;
    logic [c_J_WIDTH_DEFAULT-1:0] j;
  } addr_t;

endpackage

`default_nettype wire

// File: rtl/eda_img_ram.sv
// ============================================================================
// Module : eda_img_ram
// Brief  : Register-array image store with a combinational square window read
//          centred on (rd_i, rd_j); out-of-image taps read as invalid.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eda_img_ram #(
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 3,
  parameter int I_WIDTH      = 2,
  parameter int J_WIDTH      = 2
) (
  input  logic                                                clk,
  input  logic                                                we,
  input  logic [I_WIDTH-1:0]                                  wr_i,
  input  logic [J_WIDTH-1:0]                                  wr_j,
  input  logic [PIXEL_WIDTH-1:0]                              wr_data,
  input  logic [I_WIDTH-1:0]                                  rd_i,
  input  logic [J_WIDTH-1:0]                                  rd_j,
  output logic [WINDOW_WIDTH*WINDOW_WIDTH-1:0][PIXEL_WIDTH-1:0] win_pix,
  output logic [WINDOW_WIDTH*WINDOW_WIDTH-1:0]                win_vld
);

  localparam int c_AW   = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int c_HALF = WINDOW_WIDTH / 2;

  logic [PIXEL_WIDTH-1:0] r_mem [M*N];
  logic [c_AW-1:0]        w_wr_idx;

  assign w_wr_idx = c_AW'(int'(wr_i) * N + int'(wr_j));

  // Image contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  for (genvar r = 0; r < WINDOW_WIDTH; r++) begin : g_row
    for (genvar c = 0; c < WINDOW_WIDTH; c++) begin : g_col
      localparam int c_K = r * WINDOW_WIDTH + c;
      int   w_ni;
      int   w_nj;
      logic w_in;

      always_comb begin
        w_ni       = int'(rd_i) + r - c_HALF;
        w_nj       = int'(rd_j) + c - c_HALF;
        w_in       = (w_ni >= 0) && (w_ni < M) && (w_nj >= 0) && (w_nj < N);
        win_vld[c_K] = w_in;
        win_pix[c_K] = w_in ? r_mem[c_AW'(w_ni * N + w_nj)] : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/eda_regional_max.sv
// ============================================================================
// Module : eda_regional_max
// Brief  : Iterative regional-maximum marker over an M x N image; optional
//          8-connectivity via EDA_REGIONAL_MAX_CONN8_EN (default 4-connected).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eda_regional_max
  import eda_regional_max_pkg::*;
#(
  parameter int M            = c_M_DEFAULT,
  parameter int N            = c_N_DEFAULT,
  parameter int PIXEL_WIDTH  = c_PIXEL_WIDTH_DEFAULT,
  parameter int WINDOW_WIDTH = c_WINDOW_WIDTH_DEFAULT,
  parameter int I_WIDTH      = c_I_WIDTH_DEFAULT,
  parameter int J_WIDTH      = c_J_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   write_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   start,
  output logic                   done,
  output logic [M-1:0][N-1:0]    matrix_output
);

  localparam int c_WW   = WINDOW_WIDTH * WINDOW_WIDTH;
  localparam int c_HALF = WINDOW_WIDTH / 2;
  localparam int c_CTR  = c_HALF * WINDOW_WIDTH + c_HALF;
  localparam int c_AW   = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int c_SW   = $clog2(M * N + 1);

  state_t                             r_state;
  state_t                             w_next_state;
  logic                               w_we;
  logic                               w_done;
  logic [I_WIDTH-1:0]                 r_i;
  logic [J_WIDTH-1:0]                 r_j;
  logic [M*N-1:0]                     r_marks;
  logic [M*N-1:0]                     r_matrix;
  logic                               r_changed;
  logic [c_SW-1:0]                    r_sweep_cnt;
  logic [c_AW-1:0]                    w_ctr_idx;
  logic [c_WW-1:0][PIXEL_WIDTH-1:0]   w_win_pix;
  logic [c_WW-1:0]                    w_win_vld;
  logic [c_WW-1:0]                    w_use;
  logic [c_WW-1:0]                    w_nbr_mark;
  logic [c_WW-1:0]                    w_hit;
  logic                               w_clear;
  logic                               w_last_pix;
  logic                               w_sweep_limit;

  eda_img_ram #(
    .M            (M),
    .N            (N),
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .WINDOW_WIDTH (WINDOW_WIDTH),
    .I_WIDTH      (I_WIDTH),
    .J_WIDTH      (J_WIDTH)
  ) u_img_ram (
    .clk     (clk),
    .we      (w_we),
    .wr_i    (wr_addr[ADDR_WIDTH-1:J_WIDTH]),
    .wr_j    (wr_addr[J_WIDTH-1:0]),
    .wr_data (pixel_in),
    .rd_i    (r_i),
    .rd_j    (r_j),
    .win_pix (w_win_pix),
    .win_vld (w_win_vld)
  );

  for (genvar r = 0; r < WINDOW_WIDTH; r++) begin : g_row
    for (genvar c = 0; c < WINDOW_WIDTH; c++) begin : g_col
      localparam int c_K = r * WINDOW_WIDTH + c;
      int w_ni;
      int w_nj;

`ifdef EDA_REGIONAL_MAX_CONN8_EN
      assign w_use[c_K] = (c_K != c_CTR);
`else
      assign w_use[c_K] = (c_K != c_CTR) && ((r == c_HALF) || (c == c_HALF));
`endif

      always_comb begin
        w_ni = int'(r_i) + r - c_HALF;
        w_nj = int'(r_j) + c - c_HALF;
        w_nbr_mark[c_K] = w_win_vld[c_K] ? r_marks[c_AW'(w_ni * N + w_nj)] : 1'b1;
      end

      // A neighbour kills p if it is higher, or equal and already killed.
      assign w_hit[c_K] = w_use[c_K] && w_win_vld[c_K] &&
                          ((w_win_pix[c_K] > w_win_pix[c_CTR]) ||
                           ((w_win_pix[c_K] == w_win_pix[c_CTR]) && !w_nbr_mark[c_K]));
    end
  end

  assign w_clear       = |w_hit;
  assign w_ctr_idx     = c_AW'(int'(r_i) * N + int'(r_j));
  assign w_last_pix    = (r_i == I_WIDTH'(M - 1)) && (r_j == J_WIDTH'(N - 1));
  assign w_sweep_limit = (r_sweep_cnt == c_SW'(M * N - 1));
  assign done          = w_done;
  assign matrix_output = r_matrix;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_we = write_en;
        if (start) w_next_state = ST_INIT;
      end
      ST_INIT:  w_next_state = ST_SWEEP;
      ST_SWEEP: if (w_last_pix) w_next_state = ST_CHECK;
      ST_CHECK: w_next_state = (r_changed && !w_sweep_limit) ? ST_SWEEP : ST_DONE;
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_marks     <= '0;
      r_matrix    <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_changed   <= 1'b0;
      r_sweep_cnt <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_marks     <= '1;
          r_i         <= '0;
          r_j         <= '0;
          r_changed   <= 1'b0;
          r_sweep_cnt <= '0;
        end
        ST_SWEEP: begin
          if (w_clear) begin
            r_marks[w_ctr_idx] <= 1'b0;
            if (r_marks[w_ctr_idx]) r_changed <= 1'b1;
          end
          if (r_j == J_WIDTH'(N - 1)) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        ST_CHECK: begin
          r_changed   <= 1'b0;
          r_sweep_cnt <= r_sweep_cnt + 1'b1;
          r_i         <= '0;
          r_j         <= '0;
          // Publish on entry to DONE so the result is visible with the pulse.
          if (w_next_state == ST_DONE) r_matrix <= r_marks;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eda_regional_max.sv
// ============================================================================
// Module : tb_eda_regional_max
// Brief  : Scoreboard bench for eda_regional_max with directed images.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eda_regional_max;
  import eda_regional_max_pkg::*;

  logic            clk;
  logic            reset_n;
  logic            write_en;
  logic [3:0]      wr_addr;
  logic [7:0]      pixel_in;
  logic            start;
  logic            done;
  logic [3:0][3:0] matrix_output;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          n_cmp;
  int          n_err;
  int          n_done;
  logic        prev_done;
  logic [15:0] prev_result;

  eda_regional_max dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_en      (write_en),
    .wr_addr       (wr_addr),
    .pixel_in      (pixel_in),
    .start         (start),
    .done          (done),
    .matrix_output (matrix_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: pops expected result on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done === 1'b1) begin
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL done_width: done=%b still high, required 0", done);
      end
    end
    prev_done = done;
    if (done === 1'b1) begin
      n_done++;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done=1 with nothing pending, required 0");
      end else begin
        e = q.pop_front();
        if (matrix_output !== e.exp) begin
          n_err++;
          $display("FAIL %s: matrix_output=%h required %h", e.name, matrix_output, e.exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic wr_pix(input int i, input int j, input logic [7:0] v);
    addr_t a;
    a.i = 2'(i);
    a.j = 2'(j);
    @(negedge clk);
    write_en = 1'b1;
    wr_addr  = a;
    pixel_in = v;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        wr_pix(i, j, v);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // poke=1 tries a write and a restart while the computation is running.
  task automatic run(input string name, input logic [15:0] exp, input bit poke);
    exp_t e;
    int   d0;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
    d0 = n_done;
    pulse_start();
    repeat (3) @(negedge clk);
    check({name, "_hold"}, matrix_output, prev_result);
    if (poke) begin
      write_en = 1'b1;
      wr_addr  = 4'hF;
      pixel_in = 8'hFF;
      start    = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
      start    = 1'b0;
    end
    for (int c = 0; c < 2000 && n_done == d0; c++) @(posedge clk);
    if (n_done == d0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: done=0 after 2000 cycles, required 1", name);
      if (q.size() > 0) void'(q.pop_back());
    end
    repeat (3) @(negedge clk);
    prev_result = exp;
  endtask

  initial begin
    exp_t dummy;
    n_cmp       = 0;
    n_err       = 0;
    n_done      = 0;
    prev_done   = 1'b0;
    prev_result = 16'h0000;
    reset_n     = 1'b0;
    write_en    = 1'b0;
    wr_addr     = '0;
    pixel_in    = '0;
    start       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", {15'd0, done}, 16'h0000);
    check("reset_matrix", matrix_output, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    // Single peak at (1,2).
    fill(8'h10);
    wr_pix(1, 2, 8'h80);
    run("peak", 16'h0040, 1'b0);

    // 2x2 plateau; mid-run write to (3,3) and restart must be ignored.
    fill(8'h20);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        wr_pix(i, j, 8'h50);
    run("plateau", 16'h0033, 1'b1);

    // Plateau next to a higher pixel loses.
    fill(8'h10);
    wr_pix(0, 0, 8'h50);
    wr_pix(0, 1, 8'h50);
    wr_pix(0, 2, 8'h60);
    run("plateau_adj", 16'h0004, 1'b0);

    fill(8'h33);
    run("flat", 16'hFFFF, 1'b0);

    fill(8'h00);
    wr_pix(0, 0, 8'h40);
    wr_pix(1, 1, 8'h50);
`ifdef EDA_REGIONAL_MAX_CONN8_EN
    run("conn", 16'h0020, 1'b0);
`else
    run("conn", 16'h0021, 1'b0);
`endif

    // Reset in the middle of a sweep, then rerun on the retained image.
    fill(8'h10);
    wr_pix(1, 2, 8'h80);
    pulse_start();
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_done", {15'd0, done}, 16'h0000);
    check("midrst_matrix", matrix_output, 16'h0000);
    repeat (2) @(negedge clk);
    check("midrst_hold_matrix", matrix_output, 16'h0000);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    prev_result = 16'h0000;
    run("after_reset", 16'h0040, 1'b0);

    repeat (5) @(negedge clk);
    check("pending_empty", 16'(q.size()), 16'h0000);
    check("done_count", 16'(n_done), 16'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/eda_regional_max.md
EDA_REGIONAL_MAX -- requirements
Module: eda_regional_max

Interface
REQ-001 SHALL have parameter M, default 4, image row count.
REQ-002 SHALL have parameter N, default 4, image column count.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8, unsigned pixel width.
REQ-004 SHALL have parameter WINDOW_WIDTH, default 3, neighbourhood window side.
REQ-005 SHALL have parameters I_WIDTH, J_WIDTH, default 2 each, with ADDR_WIDTH = I_WIDTH+J_WIDTH, default 4.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-008 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port write_en, input, 1 bit, pixel write strobe.
REQ-010 SHALL have port wr_addr, input, ADDR_WIDTH bits, {row i, column j} write address.
REQ-011 SHALL have port pixel_in, input, PIXEL_WIDTH bits, pixel write data.
REQ-012 SHALL have port start, input, 1 bit, start of computation.
REQ-013 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-014 SHALL have port matrix_output, output, [M-1:0][N-1:0], where bit [i][j] = 1 marks pixel (i,j) as a regional maximum.

Function
REQ-015 SHALL write pixel_in into image RAM location (i,j) on a rising clk edge with write_en=1 in IDLE; writes in other states SHALL be ignored.
REQ-016 SHALL compute the regional maximum: a connected plateau of equal pixels with no neighbour strictly greater; out-of-image neighbours SHALL be ignored.
REQ-017 SHALL use FSM IDLE -> INIT (1 cycle: all marks = 1) -> SWEEP (M*N cycles, raster order, one pixel per cycle) -> CHECK (1 cycle) -> SWEEP again if any mark changed, else DONE (1 cycle) -> IDLE.
REQ-018 SHALL, in SWEEP, clear the mark of pixel p if any neighbour q has value(q) > value(p), or value(q) == value(p) with mark(q) = 0; updates take effect immediately.
REQ-019 SHALL accept start only in IDLE; start in other states SHALL be ignored.
REQ-020 SHALL assert done for exactly the DONE cycle, with matrix_output valid from that cycle until the next start.
REQ-021 SHALL hold matrix_output at its previous value during INIT, SWEEP and CHECK, and SHALL update it in DONE.
REQ-022 SHALL force DONE after M*N sweeps as a safety bound.
REQ-023 SHALL mark every pixel of a flat image as 1.

Reset
REQ-024 SHALL, on reset_n=0, immediately enter IDLE with done=0, matrix_output=0 and all marks cleared; image RAM contents SHALL NOT be reset.
REQ-025 SHALL abandon any computation when reset occurs mid-operation, without asserting done.

Configuration
REQ-026 SHALL use 8-connectivity (full WINDOW_WIDTH x WINDOW_WIDTH window) when EDA_REGIONAL_MAX_CONN8_EN is defined, and 4-connectivity (orthogonal neighbours only) when it is undefined.

Structure
REQ-027 SHALL place the parameter defaults, the FSM state enum and the address {i,j} typedef in shared package eda_regional_max_pkg.
REQ-028 SHALL implement image storage in sub-module eda_img_ram, a register array with combinational 3x3 window read.

Verification
REQ-029 SHALL verify a single peak: all 0x10, (1,2)=0x80 -> only bit [1][2]=1, done pulses once.
REQ-030 SHALL verify a plateau: (0..1,0..1)=0x50, rest 0x20 -> exactly those four bits set.
REQ-031 SHALL verify a plateau adjacent to a higher pixel: (0,0)=(0,1)=0x50, (0,2)=0x60, rest 0x10 -> only [0][2]=1.
REQ-032 SHALL verify a flat image: all 0x33 -> matrix_output all ones.
REQ-033 SHALL verify connectivity: (0,0)=0x40, (1,1)=0x50, rest 0 -> with the macro only [1][1]; without it [0][0] and [1][1].
REQ-034 SHALL verify reset mid-SWEEP: done stays 0 and matrix_output = 0; a new start then yields the correct result.
